// File: rtl/mod_inv_pkg.sv
// mod_inv_pkg: shared types for the binary extended-Euclid modular inverse.
//   state_e   - top-level FSM states (IDLE, LOAD, RUN, FIN)
//   step_e    - decoded RUN step, kept as an enum so it is readable in waves
//   hs_mode_e - operation select of the mod_half_sub helper
//   cnt_width - width of the iteration counter for a given step budget
package mod_inv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    FIN
  } state_e;

  typedef enum logic [2:0] {
    TERM_U,
    TERM_V,
    ERR,
    HALF_U,
    HALF_V,
    SUB_U,
    SUB_V
  } step_e;

  typedef enum logic {
    MODE_HALF,
    MODE_SUB
  } hs_mode_e;

  // The counter must be able to hold MAX_ITER itself.
  function automatic int cnt_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

endpackage

// File: rtl/mod_inv_bin_if.sv
// mod_inv_bin_if: request/response bundle of the modular inverse unit.
//   start (m->s) request, a (m->s) operand, p (m->s) odd modulus
//   busy  (s->m) operation in progress
//   done  (s->m) one-cycle result pulse
//   c     (s->m) inverse, 0 on error
//   err   (s->m) error flag, valid with done
// Modports: master = requester, slave = mod_inv_bin.
interface mod_inv_bin_if #(
  parameter int LEN = 256
);

  logic           start;
  logic [LEN-1:0] a;
  logic [LEN-1:0] p;
  logic           busy;
  logic           done;
  logic [LEN-1:0] c;
  logic           err;

  modport master (
    output start, a, p,
    input  busy, done, c, err
  );

  modport slave (
    input  start, a, p,
    output busy, done, c, err
  );

endinterface

// File: rtl/mod_inv_bin_half_sub.sv
// mod_half_sub: combinational modular helper for the inverse datapath.
//   mode in  MODE_HALF: r = x/2 mod p   (x even ? x>>1 : (x+p)>>1)
//             MODE_SUB:  r = x-y mod p   (x>=y ? x-y : x-y+p)
//   x, y in  LEN  operands in [0,p-1]
//   p    in  LEN  odd modulus
//   r    out LEN  result in [0,p-1]
// All intermediates are LEN+1 bits so the carry of x+p is not lost.
module mod_half_sub
  import mod_inv_pkg::*;
#(
  parameter int LEN = 256
) (
  input  hs_mode_e       mode,
  input  logic [LEN-1:0] x,
  input  logic [LEN-1:0] y,
  input  logic [LEN-1:0] p,
  output logic [LEN-1:0] r
);

  logic [LEN:0] xe;
  logic [LEN:0] ye;
  logic [LEN:0] pe;
  logic [LEN:0] acc;

  always_comb begin
    r   = '0;
    xe  = {1'b0, x};
    ye  = {1'b0, y};
    pe  = {1'b0, p};
    acc = xe;
    if (mode == MODE_HALF) begin
      // p is odd, so x+p is even whenever x is odd.
      acc = x[0] ? (xe + pe) : xe;
      r   = LEN'(acc >> 1);
    end else begin
      // Wrap-around of x-y is undone by adding p back in LEN+1 bits.
      acc = xe - ye;
      if (x < y) begin
        acc = acc + pe;
      end
      r = LEN'(acc);
    end
  end

endmodule

// File: rtl/mod_inv_bin.sv
// mod_inv_bin: binary extended-Euclid modular inverse c = a^-1 mod p.
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset, aborts any operation
//   bus  slave modport of mod_inv_bin_if (start/a/p in, busy/done/c/err out)
// Parameters: LEN operand width, MAX_ITER step budget before watchdog error.
// Optional macro MOD_INV_CT_EN: constant-time mode; after the result is
// captured the unit pads with frozen dummy steps until the counter reaches
// MAX_ITER, so done always fires MAX_ITER+3 edges after acceptance for
// arguments that pass the LOAD check.
module mod_inv_bin
  import mod_inv_pkg::*;
#(
  parameter int LEN      = 256,
  parameter int MAX_ITER = 2 * LEN + 2
) (
  input logic         clk,
  input logic         rst,
  mod_inv_bin_if.slave bus
);

  localparam int             CW      = cnt_width(MAX_ITER);
  localparam logic [CW-1:0]  CNT_MAX = CW'(MAX_ITER);
  localparam logic [LEN-1:0] ONE     = LEN'(1);

  state_e         state;
  logic [LEN-1:0] a_q;
  logic [LEN-1:0] p_q;
  logic [LEN-1:0] u;
  logic [LEN-1:0] v;
  logic [LEN-1:0] x1;
  logic [LEN-1:0] x2;
  logic [CW-1:0]  cnt;
`ifdef MOD_INV_CT_EN
  logic           pad;
`endif

  step_e          step;
  logic           term;
  hs_mode_e       mode_x1;
  hs_mode_e       mode_x2;
  logic [LEN-1:0] x1_nx;
  logic [LEN-1:0] x2_nx;

  // Step decode in the fixed priority order; watchdog shares the ERR step.
  always_comb begin
    step = TERM_U;
    if (u == ONE) begin
      step = TERM_U;
    end else if (v == ONE) begin
      step = TERM_V;
    end else if ((u == '0) || (v == '0)) begin
      step = ERR;
    end else if (cnt == CNT_MAX) begin
      step = ERR;
    end else if (!u[0]) begin
      step = HALF_U;
    end else if (!v[0]) begin
      step = HALF_V;
    end else if (u >= v) begin
      step = SUB_U;
    end else begin
      step = SUB_V;
    end
  end

  assign term = (step == TERM_U) || (step == TERM_V) || (step == ERR);

  always_comb begin
    mode_x1 = (step == HALF_U) ? MODE_HALF : MODE_SUB;
    mode_x2 = (step == HALF_V) ? MODE_HALF : MODE_SUB;
  end

  mod_half_sub #(.LEN(LEN)) u_hs_x1 (
    .mode (mode_x1),
    .x    (x1),
    .y    (x2),
    .p    (p_q),
    .r    (x1_nx)
  );

  mod_half_sub #(.LEN(LEN)) u_hs_x2 (
    .mode (mode_x2),
    .x    (x2),
    .y    (x1),
    .p    (p_q),
    .r    (x2_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      p_q      <= '0;
      u        <= '0;
      v        <= '0;
      x1       <= '0;
      x2       <= '0;
      cnt      <= '0;
`ifdef MOD_INV_CT_EN
      pad      <= 1'b0;
`endif
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.c    <= '0;
      bus.err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.a;
            p_q      <= bus.p;
            bus.busy <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          bus.c <= '0;
          cnt   <= '0;
`ifdef MOD_INV_CT_EN
          pad   <= 1'b0;
`endif
          // Argument errors are decided on public inputs, so they skip RUN
          // even in constant-time mode.
          if (!p_q[0] || (p_q <= ONE) || (a_q == '0) || (a_q >= p_q)) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= FIN;
          end else begin
            bus.err <= 1'b0;
            u       <= a_q;
            v       <= p_q;
            x1      <= ONE;
            x2      <= '0;
            state   <= RUN;
          end
        end

        RUN: begin
`ifdef MOD_INV_CT_EN
          if (pad) begin
            // Dummy steps: datapath frozen, only the counter moves.
            if (cnt == CNT_MAX) begin
              bus.busy <= 1'b0;
              state    <= FIN;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end else begin
`endif
          case (step)
            TERM_U: bus.c <= x1;
            TERM_V: bus.c <= x2;
            ERR: begin
              bus.err <= 1'b1;
              bus.c   <= '0;
            end
            HALF_U: begin
              u  <= u >> 1;
              x1 <= x1_nx;
            end
            HALF_V: begin
              v  <= v >> 1;
              x2 <= x2_nx;
            end
            SUB_U: begin
              u  <= u - v;
              x1 <= x1_nx;
            end
            SUB_V: begin
              v  <= v - u;
              x2 <= x2_nx;
            end
            default: ;
          endcase
          if (!term) begin
            cnt <= cnt + CW'(1);
          end
`ifdef MOD_INV_CT_EN
          // The capture cycle counts as a dummy step so the RUN phase is
          // always MAX_ITER+1 cycles long.
          else if (cnt == CNT_MAX) begin
            bus.busy <= 1'b0;
            state    <= FIN;
          end else begin
            pad <= 1'b1;
            cnt <= cnt + CW'(1);
          end
          end
`else
          else begin
            bus.busy <= 1'b0;
            state    <= FIN;
          end
`endif
        end

        FIN: begin
          bus.done <= 1'b1;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
